// File: rtl/ir_uart_tx.sv
// ir_uart_tx: byte FIFO feeding a UART 8N1 serialiser, with end-of-message reporting.
// Define IR_UART_PARITY_EN to insert an even-parity bit between data and stop.
module ir_uart_tx #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       frame_end,
   output logic       uart_tx,
   output logic       tx_busy,
   output logic       fifo_empty,
   output logic       fifo_full,
   output logic       overflow,
   output logic       frame_done
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          pending_q, pending_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   count;
   logic          push, pop, bit_end;
`ifdef IR_UART_PARITY_EN
   logic          parity_q, parity_d;
`endif

   // wr_en is a strobe with no ready: a byte offered while full is dropped and flagged.
   assign count      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL_CNT);
   assign push       = wr_en && !fifo_full;
   assign overflow_d = overflow_q | (wr_en & fifo_full);
   assign wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
   assign rd_ptr_d   = pop ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;

   assign uart_tx    = tx_q;
   assign tx_busy    = (state_q != IDLE);
   assign overflow   = overflow_q;
   assign frame_done = pending_q && fifo_empty && (state_q == IDLE);
   assign pending_d  = frame_end ? 1'b1 : (frame_done ? 1'b0 : pending_q);
   assign bit_end    = (baud_q == BAUD_LAST);

   // Line level follows the state of the current cycle, so uart_tx lags the FSM by one clock.
   always_comb begin
      state_d = state_q;
      baud_d  = bit_end ? '0 : baud_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = 1'b1;
      pop     = 1'b0;
`ifdef IR_UART_PARITY_EN
      parity_d = parity_q;
`endif
      case (state_q)
         IDLE: begin
            baud_d = '0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem_q[rd_ptr_q[AW-1:0]];
               bit_d   = '0;
               state_d = START;
`ifdef IR_UART_PARITY_EN
               parity_d = ^mem_q[rd_ptr_q[AW-1:0]];
`endif
            end
         end
         START: begin
            tx_d = 1'b0;
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            tx_d = shift_q[0];
            if (bit_end) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef IR_UART_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef IR_UART_PARITY_EN
         PARITY: begin
            tx_d = parity_q;
            if (bit_end) state_d = STOP;
         end
`endif
         STOP: begin
            tx_d = 1'b1;
            if (bit_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         tx_q       <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         pending_q  <= 1'b0;
         overflow_q <= 1'b0;
`ifdef IR_UART_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
`ifdef IR_UART_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   // Storage is deliberately not reset; pointers alone define the contents.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
   end

endmodule

// File: tb/tb_ir_uart_tx.sv
// Bench for ir_uart_tx: per-cycle reference model, line receiver and directed/random scenarios.
module tb_ir_uart_tx;

   localparam int CPB   = 10;
   localparam int DEPTH = 16;
`ifdef IR_UART_PARITY_EN
   localparam int FRAME     = 11 * CPB;
   localparam int STOP_SLOT = 10;
`else
   localparam int FRAME     = 10 * CPB;
   localparam int STOP_SLOT = 9;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       frame_end = 1'b0;
   logic       uart_tx, tx_busy, fifo_empty, fifo_full, overflow, frame_done;

   int checks = 0;
   int errors = 0;

   ir_uart_tx #(.CLK_FREQ(1000), .BAUD(100), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(rst), .wr_en(wr_en), .wr_data(wr_data), .frame_end(frame_end),
      .uart_tx(uart_tx), .tx_busy(tx_busy), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
      .overflow(overflow), .frame_done(frame_done)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic slot_val(input logic [7:0] b, input int s);
      if (s == 0) return 1'b0;
      if (s <= 8) return b[s-1];
`ifdef IR_UART_PARITY_EN
      if (s == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // reference model: queue of accepted bytes and time elapsed in the current frame
   logic [7:0] m_q[$];
   logic [7:0] popped_q[$];
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] m_cur = 8'h00;
   bit         m_busy = 0, m_pend = 0, m_ovf = 0, m_tx = 1;
   int         m_e = 0;
   int         done_cnt = 0;
   bit         full_seen = 0;
   bit         rx_active = 0, prev_tx = 1;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = 8'h00;

   initial begin
      bit pre_busy, pre_done;
      int pre_e, pre_size, slot;
      forever begin
         @(posedge clk);
         if (rst) begin
            m_q.delete();
            m_busy = 0; m_e = 0; m_pend = 0; m_ovf = 0; m_tx = 1;
         end else begin
            pre_busy = m_busy;
            pre_e    = m_e;
            pre_size = m_q.size();
            pre_done = m_pend && (pre_size == 0) && !pre_busy;
            m_tx = pre_busy ? slot_val(m_cur, pre_e / CPB) : 1'b1;
            if (m_busy) begin
               m_e++;
               if (m_e == FRAME) m_busy = 0;
            end
            if (!pre_busy && pre_size > 0) begin
               m_cur = m_q.pop_front();
               popped_q.push_back(m_cur);
               m_e = 0;
               m_busy = 1;
            end
            if (wr_en) begin
               if (pre_size < DEPTH) m_q.push_back(wr_data);
               else m_ovf = 1;
            end
            m_pend = frame_end || (m_pend && !pre_done);
         end
         #1;
         chk("uart_tx", uart_tx, m_tx);
         chk("tx_busy", tx_busy, m_busy);
         chk("fifo_empty", fifo_empty, m_q.size() == 0);
         chk("fifo_full", fifo_full, m_q.size() == DEPTH);
         chk("overflow", overflow, m_ovf);
         chk("frame_done", frame_done, m_pend && m_q.size() == 0 && !m_busy);
         if (frame_done) done_cnt++;
         if (fifo_full) full_seen = 1;
         // line receiver sampling mid-bit
         if (rst) rx_active = 0;
         else if (!rx_active) begin
            if (prev_tx && !uart_tx) begin
               rx_active = 1;
               rx_cnt = 0;
            end
         end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
               slot = rx_cnt / CPB;
               if (slot >= 1 && slot <= 8) rx_byte[slot-1] = uart_tx;
`ifdef IR_UART_PARITY_EN
               if (slot == 9) chk("rx_parity", uart_tx, ^rx_byte);
`endif
               if (slot == STOP_SLOT) begin
                  chk("rx_stop", uart_tx, 1'b1);
                  rx_q.push_back(rx_byte);
                  rx_active = 0;
               end
            end
         end
         prev_tx = uart_tx;
      end
   end

   // driver tasks
   task automatic wait_idle(input int budget);
      bit ok = 0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk); #2;
         if (!tx_busy && fifo_empty && !rx_active) begin
            ok = 1;
            break;
         end
      end
      chk("idle_timeout", ok, 1'b1);
      repeat (3) @(posedge clk);
      #2;
   endtask

   task automatic check_rx(input string name);
      chk({name, "_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         chk({name, "_byte"}, rx_q[i], exp_q[i]);
      rx_q.delete();
      exp_q.delete();
   endtask

   task automatic one_byte(input logic [7:0] b, input logic [10:0] slots, input int exp_busy);
      int busy_cnt = 0;
      @(negedge clk); wr_en = 1; wr_data = b;
      @(posedge clk);
      @(negedge clk); wr_en = 0;
      for (int k = 1; k <= 125; k++) begin
         @(posedge clk); #2;
         if (tx_busy) busy_cnt++;
         if (k == 1) chk("line_high_k1", uart_tx, 1'b1);
         if (k >= 7 && (k - 7) % 10 == 0 && (k - 7) / 10 <= 10)
            chk("slot_level", uart_tx, slots[(k - 7) / 10]);
      end
      chk("busy_cycles", busy_cnt, exp_busy);
      wait_idle(500);
   endtask

   logic [7:0] burst_b [12] = '{8'h50, 8'h4C, 8'h41, 8'h59, 8'h2F, 8'h50,
                                8'h41, 8'h55, 8'h53, 8'h45, 8'h0D, 8'h0A};

   initial begin
      int d0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_uart_tx", uart_tx, 1'b1);
      chk("rst_busy", tx_busy, 1'b0);
      chk("rst_empty", fifo_empty, 1'b1);
      chk("rst_full", fifo_full, 1'b0);
      chk("rst_overflow", overflow, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      @(negedge clk); rst = 0;
      repeat (2) @(posedge clk);

      // single byte with hand-computed line slots
`ifdef IR_UART_PARITY_EN
      one_byte(8'h35, 11'h46A, 110);
      one_byte(8'h31, 11'h662, 110);
      one_byte(8'h33, 11'h466, 110);
      exp_q = '{8'h35, 8'h31, 8'h33};
`else
      one_byte(8'h35, 11'h66A, 100);
      exp_q = '{8'h35};
`endif
      check_rx("single_rx");

      // burst message followed by frame_end
      d0 = done_cnt;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk); wr_en = 1; wr_data = burst_b[i];
      end
      @(negedge clk); wr_en = 0; frame_end = 1;
      @(negedge clk); frame_end = 0;
      wait_idle(3000);
      for (int i = 0; i < 12; i++) exp_q.push_back(burst_b[i]);
      check_rx("burst_rx");
      chk("burst_done_pulses", done_cnt - d0, 1);
      chk("burst_overflow", overflow, 1'b0);

      // empty frame
      @(negedge clk); frame_end = 1;
      @(posedge clk); #2;
      chk("empty_frame_done", frame_done, 1'b1);
      @(negedge clk); frame_end = 0;
      @(posedge clk); #2;
      chk("empty_frame_clear", frame_done, 1'b0);

      // overflow: 20 back-to-back writes
      full_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); wr_en = 1; wr_data = 8'(i);
      end
      @(negedge clk); wr_en = 0;
      @(posedge clk); #2;
      chk("ovf_set", overflow, 1'b1);
      chk("ovf_full_seen", full_seen, 1'b1);
      wait_idle(4000);
      for (int i = 0; i <= 16; i++) exp_q.push_back(8'(i));
      check_rx("ovf_rx");
      chk("ovf_sticky", overflow, 1'b1);

      // reset during data bit 3 of the first of three queued bytes
      @(negedge clk); wr_en = 1; wr_data = 8'hA5;
      @(posedge clk);
      @(negedge clk); wr_data = 8'h5A;
      @(posedge clk);
      @(negedge clk); wr_data = 8'h3C;
      @(posedge clk);
      @(negedge clk); wr_en = 0;
      repeat (43) @(posedge clk);
      @(negedge clk);
      chk("pre_reset_bit3", uart_tx, 1'b0);
      rst = 1; #1;
      chk("async_uart_tx", uart_tx, 1'b1);
      chk("async_empty", fifo_empty, 1'b1);
      chk("async_busy", tx_busy, 1'b0);
      chk("async_overflow", overflow, 1'b0);
      repeat (2) @(negedge clk);
      rst = 0;
      begin
         int lows = 0;
         for (int i = 0; i < 150; i++) begin
            @(posedge clk); #2;
            if (!uart_tx || tx_busy) lows++;
         end
         chk("post_reset_quiet", lows, 0);
      end
      check_rx("reset_rx");
      popped_q.delete();

      // randomized stream with occasional frame ends
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         wr_en = ($urandom_range(0, 7) == 0);
         wr_data = 8'($urandom_range(0, 255));
         frame_end = ($urandom_range(0, 49) == 0);
      end
      @(negedge clk); wr_en = 0; frame_end = 0;
      wait_idle(40000);
      exp_q = popped_q;
      check_rx("random_rx");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ir_uart_tx.md
Name: ir_uart_tx

Overview:
- Downstream stage of the IR key-to-ASCII formatter.
- Accepts the formatter's back-to-back byte strobes, which arrive one byte per clock with no back-pressure, and buffers them in a small synchronous FIFO.
- Serialises the buffered bytes onto a UART 8N1 line, LSB first.
- Reports when the last byte of a framed message (text + CR LF, ended by the formatter's stop pulse) has fully left the line.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. Derived localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, 434 at defaults); must be >= 2.
- FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 16 (largest message is 12 bytes).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  byte strobe from the formatter; one byte per high cycle.
- wr_data  in  8  byte qualified by wr_en.
- frame_end  in  1  end-of-message pulse from the formatter (its stop output).
- uart_tx  out  1  serial line; idle high.
- tx_busy  out  1  high while the serialiser is outside IDLE.
- fifo_empty  out  1  FIFO holds no bytes.
- fifo_full  out  1  FIFO holds FIFO_DEPTH bytes.
- overflow  out  1  sticky; set when a byte is dropped; cleared only by reset.
- frame_done  out  1  one-cycle pulse when a framed message has been completely transmitted.

Behaviour:
- Reset values:
  - uart_tx=1, tx_busy=0, fifo_empty=1, fifo_full=0, overflow=0, frame_done=0.
  - Pointers, count and the pending flag are 0; FSM is in IDLE.
  - FIFO storage is not reset.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide.
  - Write when wr_en && !fifo_full. Full is evaluated from the registered count, so a pop in the same cycle does not free space for that cycle's write.
  - wr_en && fifo_full: the byte is dropped and overflow is set on the next edge.
  - Simultaneous push and pop with the FIFO not full: the count is unchanged.
  - fifo_empty and fifo_full are registered-state decodes. A write into an empty FIFO deasserts fifo_empty on the next edge.
- Serialiser FSM (states IDLE, START, DATA, STOP):
  - IDLE: uart_tx=1. If !fifo_empty, pop the head into the shift register, clear the baud counter and bit index, and go to START.
  - START: uart_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: uart_tx=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit index. After bit 7 completes, go to STOP.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - The baud counter runs 0..CLKS_PER_BIT-1 and wraps at each bit boundary.
- Latency and timing:
  - A byte written at edge N into an empty FIFO with the FSM idle is popped at N+1; uart_tx falls at N+2.
  - Each byte occupies 10*CLKS_PER_BIT cycles plus 1 IDLE cycle before the next START.
- uart_tx is registered, so there are no glitches.
- Framing:
  - frame_end sets the pending flag.
  - When pending && fifo_empty && FSM in IDLE, frame_done pulses one cycle and pending clears.
  - A frame_end arriving in the same cycle as the frame_done condition keeps pending set.
- Data transparency: byte 0xFF written with wr_en=1 (unknown key) is transmitted like any other byte.
- Reset mid-byte: uart_tx returns high immediately (asynchronous) and buffered bytes are discarded.

Optional Feature:
- Macro IR_UART_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even parity of the 8 data bits (XOR of the bits) for CLKS_PER_BIT cycles. Each byte then occupies 11*CLKS_PER_BIT + 1 cycles.
- Undefined: no parity state; plain 8N1.

Test Plan:
- Single byte (CLK_FREQ=1000, BAUD=100, so CLKS_PER_BIT=10): wr_data=0x35 for one cycle.
  - uart_tx low 10 cycles starting 2 cycles after the write.
  - Then bits 1,0,1,0,1,1,0,0 at 10 cycles each, then high.
  - tx_busy high for exactly 100 cycles.
- Burst: 12 consecutive wr_en cycles carrying "PLAY/PAUSE" (0x50 0x4C 0x41 0x59 0x2F 0x50 0x41 0x55 0x53 0x45) then 0x0D 0x0A, followed by a frame_end pulse.
  - 12 bytes appear on uart_tx in order; overflow stays 0.
  - frame_done pulses once, 1 cycle after the last stop bit ends.
- Overflow: 20 consecutive writes of 0x00..0x13 with FIFO_DEPTH=16.
  - Bytes 0x00..0x10 (17 bytes) are transmitted; 0x11..0x13 are dropped.
  - fifo_full is seen high; overflow=1 and stays 1 until reset.
- Reset mid-transmission: assert reset during DATA bit 3 of a 3-byte queue.
  - uart_tx=1 in the same cycle, fifo_empty=1.
  - After release, the line stays idle with no residual bytes.
- Empty frame: frame_end pulse with the FIFO empty and the FSM idle → frame_done high on the following cycle only.
- IR_UART_PARITY_EN defined: bytes 0x31 and 0x33 are sent; parity bits are 1 and 0 respectively; each frame lasts 110 cycles plus 1 idle.
